// File: rtl/tile_renderer.sv
// VGA read-side renderer: generates pixel timing, fetches tile codes and labyrinth
// pixels from synchronous RAMs, expands 4x4 sprites at 4x scale, 3-stage pipeline.
module tile_renderer #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int BLINK_BIT    = 4,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic [2:0]  pac_dir,
    output logic [10:0] map_addr,
    input  logic [3:0]  map_data,
    output logic [14:0] wall_addr,
    input  logic [2:0]  wall_data,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        frame_start
);
    localparam logic [15:0] PELLET_BMP = 16'h0040;
    localparam logic [15:0] SUPER_BMP  = 16'h0660;
    localparam logic [15:0] PAC_IDLE   = 16'h6FF6;
    localparam logic [15:0] PAC_RIGHT  = 16'h6776;
    localparam logic [15:0] PAC_LEFT   = 16'h6EE6;
    localparam logic [15:0] PAC_UP     = 16'h6FF9;
    localparam logic [15:0] PAC_DOWN   = 16'h9FF6;
    // Two bits per sprite position, position 0 in the least significant pair.
    localparam logic [31:0] GHOST_BMP  = 32'h4196_5514;
    localparam logic [23:0] WHITE      = 24'hFFFFFF;

    logic [9:0]  h_reg, v_reg;
    logic [4:0]  frame_cnt_reg;
    logic [2:0]  dir_lat_reg;
    logic        active, h_last, v_last, frame_origin;
    logic        s1_active, s1_hs_on, s1_vs_on, s1_fs;
    logic [3:0]  s1_pos;
    logic        s2_active, s2_hs_on, s2_vs_on, s2_fs;
    logic [3:0]  s2_pos;
    logic [15:0] pac_bmp;
    logic [1:0]  ghost_code;
    logic [23:0] pixel;

    assign h_last       = (h_reg == 10'(H_TOTAL - 1));
    assign v_last       = (v_reg == 10'(V_TOTAL - 1));
    assign active       = (h_reg < 10'(H_ACTIVE)) && (v_reg < 10'(V_ACTIVE));
    assign frame_origin = (h_reg == 10'd0) && (v_reg == 10'd0);

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            h_reg         <= '0;
            v_reg         <= '0;
            frame_cnt_reg <= '0;
            dir_lat_reg   <= '0;
        end else begin
            // Direction is sampled once per frame so a sprite never tears mid-frame.
            if (frame_origin) begin
                dir_lat_reg   <= pac_dir;
                frame_cnt_reg <= frame_cnt_reg + 5'd1;
            end
            if (h_last) begin
                h_reg <= '0;
                v_reg <= v_last ? 10'd0 : v_reg + 10'd1;
            end else begin
                h_reg <= h_reg + 10'd1;
            end
        end
    end

    // Sync flags travel active-high so cleared pipeline stages read as "not in sync".
    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            map_addr  <= '0;
            wall_addr <= '0;
            s1_active <= 1'b0;
            s1_hs_on  <= 1'b0;
            s1_vs_on  <= 1'b0;
            s1_fs     <= 1'b0;
            s1_pos    <= '0;
        end else begin
            if (active) begin
                map_addr  <= 11'(v_reg[9:4]) * 11'd40 + 11'(h_reg[9:4]);
                wall_addr <= 15'(v_reg[9:2]) * 15'd160 + 15'(h_reg[9:2]);
            end
            s1_active <= active;
            s1_hs_on  <= (h_reg >= 10'(H_SYNC_START)) && (h_reg <= 10'(H_SYNC_END));
            s1_vs_on  <= (v_reg >= 10'(V_SYNC_START)) && (v_reg <= 10'(V_SYNC_END));
            s1_fs     <= frame_origin;
            s1_pos    <= {v_reg[3:2], h_reg[3:2]};
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            s2_active <= 1'b0;
            s2_hs_on  <= 1'b0;
            s2_vs_on  <= 1'b0;
            s2_fs     <= 1'b0;
            s2_pos    <= '0;
        end else begin
            s2_active <= s1_active;
            s2_hs_on  <= s1_hs_on;
            s2_vs_on  <= s1_vs_on;
            s2_fs     <= s1_fs;
            s2_pos    <= s1_pos;
        end
    end

    always_comb begin
        pac_bmp = PAC_IDLE;
        case (dir_lat_reg)
            3'd1:    pac_bmp = PAC_RIGHT;
            3'd2:    pac_bmp = PAC_LEFT;
            3'd3:    pac_bmp = PAC_DOWN;
            3'd4:    pac_bmp = PAC_UP;
            default: pac_bmp = PAC_IDLE;
        endcase
        ghost_code = GHOST_BMP[{s2_pos, 1'b0} +: 2];
        pixel = 24'h0;
        case (map_data)
            4'd2: if (PELLET_BMP[s2_pos]) pixel = WHITE;
            4'd3: if (SUPER_BMP[s2_pos] && !frame_cnt_reg[BLINK_BIT]) pixel = WHITE;
            4'd4: if (pac_bmp[s2_pos]) pixel = 24'hFFFF00;
            4'd5, 4'd6, 4'd7, 4'd8: begin
                if (ghost_code == 2'd2) begin
                    pixel = WHITE;
                end else if (ghost_code == 2'd1) begin
                    case (map_data)
                        4'd5:    pixel = 24'hFF8000;
                        4'd6:    pixel = 24'h00FFFF;
                        4'd7:    pixel = 24'hFF0000;
                        default: pixel = 24'hFFBEC8;
                    endcase
                end
            end
            default: if (wall_data == 3'b001) pixel = 24'h0000FA;
        endcase
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            red         <= s2_active ? pixel[23:16] : 8'd0;
            green       <= s2_active ? pixel[15:8]  : 8'd0;
            blue        <= s2_active ? pixel[7:0]   : 8'd0;
            hsync       <= ~s2_hs_on;
            vsync       <= ~s2_vs_on;
            blank_n     <= s2_active;
            frame_start <= s2_fs;
        end
    end
endmodule
